// File: rtl/binary_to_decimal_driver_if.sv
// Code handshake between a code source and the decimal lamp driver.
// The source drives in_valid/B; the driver answers with in_ready.
interface binary_to_decimal_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] B;

  modport master (
    output in_valid,
    output B,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  B,
    output in_ready
  );
endinterface

// File: rtl/binary_to_decimal_driver.sv
// Accepts a 4-bit code, lights the matching decimal lamp for HOLD_CYCLES,
// blanks for GAP_CYCLES, then pulses done and returns to IDLE.
module binary_to_decimal_driver #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  binary_to_decimal_driver_if.slave   bus,
  output logic [9:0]                  O,
  output logic                        busy,
  output logic                        err,
  output logic                        done
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_LOAD_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      code_q;
  logic [9:0]      o_q;
  logic            err_q;
  logic            done_q;
  logic            busy_q;
  logic            ready_q;

  // Illegal codes (>9) map to a dark display rather than wrapping.
  function automatic logic [9:0] decode(input logic [3:0] code);
    logic [9:0] lamp;
    if (code <= 4'd9) begin
      lamp = 10'd1 << code;
    end else begin
      lamp = 10'd0;
    end
    return lamp;
  endfunction

  // Sequencer: accept, hold the lamp, blank for the gap, then signal done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= 4'd0;
      o_q     <= 10'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid && ready_q) begin
            code_q  <= bus.B;
            o_q     <= decode(bus.B);
            err_q   <= (bus.B > 4'd9);
            cnt_q   <= HOLD_LOAD;
            state_q <= SHOW;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            o_q     <= 10'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            o_q <= 10'd0;
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
              cnt_q   <= GAP_LOAD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end else begin
            // Refresh from the captured code so B is never looked at here.
            o_q   <= decode(code_q);
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        GAP: begin
          o_q <= 10'd0;
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          o_q     <= 10'd0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign O            = o_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign done         = done_q;
  assign bus.in_ready = ready_q;

endmodule

// File: tb/tb_binary_to_decimal_driver.sv
// Directed bench: default build (HOLD=4, GAP=1) and a HOLD=1, GAP=0 build.
module tb_binary_to_decimal_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic [9:0] o_a, o_b;
  logic       busy_a, err_a, done_a;
  logic       busy_b, err_b, done_b;

  binary_to_decimal_driver_if bus_a ();
  binary_to_decimal_driver_if bus_b ();

  binary_to_decimal_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_a.slave),
    .O    (o_a),
    .busy (busy_a),
    .err  (err_a),
    .done (done_a)
  );

  binary_to_decimal_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_b.slave),
    .O    (o_b),
    .busy (busy_b),
    .err  (err_b),
    .done (done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One isolated code on the default build, B scrambled during SHOW.
  task automatic run_a(input logic [3:0] code, input logic [9:0] exp_o, input logic exp_err);
    bus_a.B = code;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.B = ~code;
    chk("a_err_at_accept", 10'(err_a), 10'(exp_err));
    for (int j = 0; j < 4; j++) begin
      chk("a_show_o", o_a, exp_o);
      chk("a_show_ready", 10'(bus_a.in_ready), 10'd0);
      chk("a_show_busy", 10'(busy_a), 10'd1);
      tick();
    end
    chk("a_gap_o", o_a, 10'd0);
    chk("a_gap_done", 10'(done_a), 10'd0);
    tick();
    chk("a_done", 10'(done_a), 10'd1);
    chk("a_done_ready", 10'(bus_a.in_ready), 10'd1);
    chk("a_done_busy", 10'(busy_a), 10'd0);
    chk("a_err_hold", 10'(err_a), 10'(exp_err));
  endtask

  int         acc [3];
  logic [3:0] b2b_code [3];
  logic [9:0] b2b_o [3];

  initial begin
    bus_a.in_valid = 1'b0;
    bus_a.B = 4'd0;
    bus_b.in_valid = 1'b0;
    bus_b.B = 4'd0;
    b2b_code[0] = 4'd2; b2b_o[0] = 10'b0000000100;
    b2b_code[1] = 4'd5; b2b_o[1] = 10'b0000100000;
    b2b_code[2] = 4'd8; b2b_o[2] = 10'b0100000000;

    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_o", o_a, 10'd0);
    chk("rst_err", 10'(err_a), 10'd0);
    chk("rst_busy", 10'(busy_a), 10'd0);
    chk("rst_done", 10'(done_a), 10'd0);
    chk("rst_ready", 10'(bus_a.in_ready), 10'd1);
    chk("rst_b_ready", 10'(bus_b.in_ready), 10'd1);
    tick();
    chk("idle_o", o_a, 10'd0);
    chk("idle_ready", 10'(bus_a.in_ready), 10'd1);

    // Single and boundary codes
    run_a(4'd7,  10'b0010000000, 1'b0);
    run_a(4'd0,  10'b0000000001, 1'b0);
    run_a(4'd9,  10'b1000000000, 1'b0);
    run_a(4'd10, 10'd0,          1'b1);
    run_a(4'd15, 10'd0,          1'b1);
    run_a(4'd3,  10'b0000001000, 1'b0);
    tick();
    chk("a_done_one_cycle", 10'(done_a), 10'd0);

    // Back-to-back with in_valid held high
    bus_a.in_valid = 1'b1;
    bus_a.B = b2b_code[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      acc[k] = cyc;
      bus_a.B = 4'd9;
      for (int j = 0; j < 4; j++) begin
        chk("b2b_show_o", o_a, b2b_o[k]);
        if (j == 2) bus_a.B = (k < 2) ? b2b_code[k+1] : 4'd0;
        tick();
      end
      chk("b2b_gap_o", o_a, 10'd0);
      tick();
      chk("b2b_done", 10'(done_a), 10'd1);
      chk("b2b_ready", 10'(bus_a.in_ready), 10'd1);
      if (k == 2) bus_a.in_valid = 1'b0;
    end
    chk("b2b_spacing_01", 10'(acc[1] - acc[0]), 10'd6);
    chk("b2b_spacing_12", 10'(acc[2] - acc[1]), 10'd6);
    tick();
    chk("b2b_end_done", 10'(done_a), 10'd0);
    chk("b2b_end_busy", 10'(busy_a), 10'd0);

    // Reset in the second SHOW cycle, with err set beforehand
    run_a(4'd12, 10'd0, 1'b1);
    tick();
    bus_a.B = 4'd4;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    chk("mid_show1_o", o_a, 10'b0000010000);
    tick();
    chk("mid_show2_o", o_a, 10'b0000010000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_o", o_a, 10'd0);
    chk("mid_rst_busy", 10'(busy_a), 10'd0);
    chk("mid_rst_err", 10'(err_a), 10'd0);
    chk("mid_rst_done", 10'(done_a), 10'd0);
    tick();
    chk("mid_rst_no_done", 10'(done_a), 10'd0);
    chk("mid_rst_ready", 10'(bus_a.in_ready), 10'd1);
    run_a(4'd1, 10'b0000000010, 1'b0);

    // HOLD=1, GAP=0 build
    bus_b.B = 4'd6;
    bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    chk("b_show_o", o_b, 10'b0001000000);
    chk("b_show_busy", 10'(busy_b), 10'd1);
    tick();
    chk("b_idle_o", o_b, 10'd0);
    chk("b_done", 10'(done_b), 10'd1);
    chk("b_done_ready", 10'(bus_b.in_ready), 10'd1);
    tick();
    chk("b_done_clear", 10'(done_b), 10'd0);

    bus_b.B = 4'd3;
    bus_b.in_valid = 1'b1;
    tick();
    chk("b_tp1_o", o_b, 10'b0000001000);
    bus_b.B = 4'd4;
    tick();
    chk("b_tp1_done", 10'(done_b), 10'd1);
    chk("b_tp1_o_off", o_b, 10'd0);
    tick();
    chk("b_tp2_o", o_b, 10'b0000010000);
    chk("b_tp2_err", 10'(err_b), 10'd0);
    bus_b.in_valid = 1'b0;
    tick();
    chk("b_tp2_done", 10'(done_b), 10'd1);
    tick();
    chk("b_end_busy", 10'(busy_b), 10'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
